// File: rtl/down_timer.sv
// Programmable down-counting timer with prescaled ticks, one-shot/periodic
// modes, pause/resume and abort; all outputs come straight from registers.
module down_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      reload_value,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  expire,
  output logic                  busy,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]      COUNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE   = PRESCALE_W'(1);

  state_t                cur_state;
  logic [PRESCALE_W-1:0] psc;
  logic [WIDTH-1:0]      lat_reload;
  logic [PRESCALE_W-1:0] lat_prescale;
  logic                  lat_periodic;

  assign state = cur_state;
  assign busy  = (cur_state == RUN) || (cur_state == HOLD);

  // Priority per edge is stop, then a valid start, then pause, then the tick.
  // A start with a zero reload value is treated as if start were low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= IDLE;
      count        <= '0;
      expire       <= 1'b0;
      psc          <= '0;
      lat_reload   <= '0;
      lat_prescale <= '0;
      lat_periodic <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (stop) begin
        cur_state <= IDLE;
        count     <= '0;
        psc       <= '0;
      end else if (start && (reload_value != '0)) begin
        lat_reload   <= reload_value;
        lat_prescale <= prescale;
        lat_periodic <= periodic;
        count        <= reload_value;
        psc          <= '0;
        cur_state    <= RUN;
      end else begin
        case (cur_state)
          RUN: begin
            if (pause) begin
              cur_state <= HOLD;
            end else if (psc == lat_prescale) begin
              psc <= '0;
              // Terminal transition fires at count==1, so count never underflows.
              if (count > COUNT_ONE) begin
                count <= count - COUNT_ONE;
              end else if (lat_periodic) begin
                count  <= lat_reload;
                expire <= 1'b1;
              end else begin
                count     <= '0;
                expire    <= 1'b1;
                cur_state <= DONE;
              end
            end else begin
              psc <= psc + PSC_ONE;
            end
          end
          HOLD: begin
            if (!pause) begin
              cur_state <= RUN;
            end
          end
          default: begin
            cur_state <= cur_state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_down_timer;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  pause = 1'b0;
  logic                  periodic = 1'b0;
  logic [WIDTH-1:0]      reload_value = '0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic [WIDTH-1:0]      count;
  logic                  expire;
  logic                  busy;
  logic [1:0]            state;

  int checks = 0;
  int errors = 0;

  // Model: remaining edges until the next tick instead of a prescaler counter
  int m_state = 0;
  int m_count = 0;
  int m_left = 0;
  int m_reload = 0;
  int m_prescale = 0;
  bit m_periodic = 1'b0;
  bit m_expire = 1'b0;

  down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .reload_value(reload_value), .prescale(prescale),
    .count(count), .expire(expire), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_state = S_IDLE; m_count = 0; m_left = 0; m_expire = 1'b0;
    m_reload = 0; m_prescale = 0; m_periodic = 1'b0;
  endtask

  task automatic modelStep();
    m_expire = 1'b0;
    if (stop) begin
      m_state = S_IDLE;
      m_count = 0;
    end else if (start && reload_value != 0) begin
      m_reload   = int'(reload_value);
      m_prescale = int'(prescale);
      m_periodic = periodic;
      m_count    = m_reload;
      m_left     = m_prescale + 1;
      m_state    = S_RUN;
    end else if (m_state == S_RUN) begin
      if (pause) begin
        m_state = S_HOLD;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_left = m_prescale + 1;
          if (m_count > 1) begin
            m_count = m_count - 1;
          end else begin
            m_expire = 1'b1;
            if (m_periodic) m_count = m_reload;
            else begin
              m_count = 0;
              m_state = S_DONE;
            end
          end
        end
      end
    end else if (m_state == S_HOLD && !pause) begin
      m_state = S_RUN;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("count", int'(count), m_count);
    checkVal("expire", int'(expire), int'(m_expire));
    checkVal("state", int'(state), m_state);
    checkVal("busy", int'(busy), int'(m_state == S_RUN || m_state == S_HOLD));
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput();
  end

  task automatic applyStimulus(input bit st, input bit sp, input bit pa, input bit per,
                               input int rv, input int ps);
    @(negedge clk);
    start = st; stop = sp; pause = pa; periodic = per;
    reload_value = rv[WIDTH-1:0];
    prescale = ps[PRESCALE_W-1:0];
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit pause_lvl;
    int rv;
    int ps;
    bit st;
    repeat (2) @(negedge clk);
    checkVal("reset state", int'(state), 0);
    checkVal("reset count", int'(count), 0);
    rst_n = 1'b1;

    $display("[TB] one-shot R=3 P=0");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    checkVal("t1 load", int'(count), 3);
    idle(); checkVal("t1 c2", int'(count), 2);
    idle(); checkVal("t1 c1", int'(count), 1);
    idle();
    checkVal("t1 c0", int'(count), 0);
    checkVal("t1 expire", int'(expire), 1);
    checkVal("t1 done", int'(state), 3);
    checkVal("t1 busy", int'(busy), 0);
    idle(); checkVal("t1 expire drop", int'(expire), 0);

    $display("[TB] periodic R=2 P=2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2, 2);
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (k == 3) checkVal("t2 c1", int'(count), 1);
      if (k == 6 || k == 12) begin
        checkVal("t2 expire", int'(expire), 1);
        checkVal("t2 reload", int'(count), 2);
        checkVal("t2 run", int'(state), 1);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    $display("[TB] pause R=5 P=0");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    idle(); idle();
    checkVal("t3 pre-pause", int'(count), 3);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      checkVal("t3 hold count", int'(count), 3);
      checkVal("t3 hold state", int'(state), 2);
      checkVal("t3 hold busy", int'(busy), 1);
    end
    idle(); checkVal("t3 resume", int'(count), 3);
    idle(); checkVal("t3 c2", int'(count), 2);
    idle(); idle();
    checkVal("t3 c0", int'(count), 0);
    checkVal("t3 expire", int'(expire), 1);

    $display("[TB] restart and abort");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4, 0);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 7, 0);
    checkVal("t4 restart count", int'(count), 7);
    checkVal("t4 restart state", int'(state), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7, 0);
    checkVal("t4 stop state", int'(state), 0);
    checkVal("t4 stop count", int'(count), 0);

    $display("[TB] zero reload");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checkVal("t5 state", int'(state), 0);
    checkVal("t5 expire", int'(expire), 0);
    idle(); idle();

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4, 0);
    idle(); idle();
    checkVal("t6 pre-reset", int'(count), 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("t6 rst count", int'(count), 0);
    checkVal("t6 rst state", int'(state), 0);
    checkVal("t6 rst expire", int'(expire), 0);
    checkVal("t6 rst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle();
    checkVal("t6 stays idle", int'(state), 0);

    $display("[TB] random traffic");
    pause_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0) pause_lvl = ~pause_lvl;
      rv = ($urandom % 8 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 6));
      if ($urandom % 10 == 0) rv = 0;
      st = ($urandom % 16 == 0);
      if (rv == 0 && m_state != S_IDLE) rv = 1;
      ps = ($urandom % 6 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      applyStimulus(st, ($urandom % 50 == 0), pause_lvl, 1'($urandom % 2), rv, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting timer: loads a start value, decrements once per prescaled tick, and flags expiry when the count reaches zero.
- Complement of the team's up-counter submodule: counts down from a loaded value instead of up to a ceiling.
- Supports one-shot and periodic (auto-reload) modes, plus pause/resume and abort.
- Used as the timeout/interval source for control FSMs in the design.

Parameters:
WIDTH, 8, width of count and reload value
PRESCALE_W, 4, width of prescale divider setting

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
start  input  1  load reload_value/prescale/periodic and begin counting
stop  input  1  abort; return to IDLE
pause  input  1  level; freeze counting while high
periodic  input  1  1 = auto-reload on expiry, 0 = one-shot
reload_value  input  WIDTH  start count, must be nonzero
prescale  input  PRESCALE_W  tick every (prescale+1) clk cycles
count  output  WIDTH  current remaining count (registered)
expire  output  1  one-cycle pulse when count reaches terminal
busy  output  1  high in RUN or HOLD
state  output  2  IDLE=0, RUN=1, HOLD=2, DONE=3

Behaviour:
- Reset (async, rst_n low): state=IDLE, count=0, expire=0, busy=0, internal prescaler counter psc=0, latched reload/prescale/periodic registers=0.
- All outputs are registered. busy is decoded from the registered state.
- Per-edge priority: stop > start > pause > tick.
- stop (any state): state=IDLE, count=0, psc=0, expire=0 on the next edge.
- start:
  - Accepted in any state, including RUN/HOLD, where it restarts the timer.
  - Effect: latch reload_value, prescale and periodic; count=reload_value, psc=0, state=RUN.
  - start with reload_value==0 is ignored: state, count and expire are unchanged.
- Tick generation:
  - Only in RUN with pause=0.
  - If psc==latched prescale: tick, psc<=0; else psc<=psc+1.
  - prescale=0 gives a tick every cycle.
- On tick:
  - count>1: count<=count-1.
  - count==1, one-shot: count<=0, expire=1 next cycle, state=DONE.
  - count==1, periodic: count<=latched reload, expire=1 next cycle, stay RUN, psc<=0.
- expire is high for exactly one cycle per expiry and deasserts on the following edge.
- Latency: start sampled at edge E0 -> count=R after E0. Expiry takes effect at edge E0 + R*(P+1), where R = reload value and P = prescale.
  - Example: R=3, P=0 -> count 3,2,1,0 after edges E0..E3; expire high after E3.
- pause:
  - RUN with pause=1 -> HOLD on the next edge; no tick that edge; psc and count frozen.
  - HOLD with pause=0 -> RUN; psc resumes from its frozen value.
  - pause is ignored in IDLE and DONE.
- DONE: count holds 0; stays until start or stop.
- IDLE: count holds 0; only start leaves IDLE.
- Counter arithmetic is WIDTH-bit unsigned. Underflow cannot occur, because the terminal transition happens at count==1.
- Reset mid-operation aborts immediately. No expire pulse is generated.

Test Plan:
- Reset, then start with R=3, P=0, one-shot -> count 3,2,1,0 on successive cycles; expire high one cycle with count=0; state=DONE; busy=0.
- R=2, P=2, periodic -> count decrements every 3 cycles; expire pulses every 6 cycles with count reloaded to 2; state stays RUN.
- R=5, P=0; pause high for 4 cycles after count=3 -> count holds 3, state=HOLD, busy=1; after release it resumes 2,1,0 with no extra or lost ticks.
- R=4 running; start with R=7 asserted together with pause -> count=7, state=RUN (start wins). Next, stop asserted together with start -> IDLE, count=0.
- start with reload_value=0 in IDLE -> no state change, count=0, expire never asserted.
- rst_n pulsed low while count=2 in RUN -> immediate IDLE, count=0, expire=0; timer stays idle until the next start.
